// File: rtl/bar_frame_scheduler_pkg.sv
// Shared definitions for the bar frame scheduler slice.
// Holds the scheduler state encoding and the bar/magnitude geometry used by
// the top-level sequencer and the per-bar target calculator.
package bar_frame_scheduler_pkg;
    localparam int NUM_BARS = 4;
    localparam int BAR_W    = 10;
    localparam int MAG_W    = 16;
    localparam int IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;
endpackage

// File: rtl/bar_frame_scheduler_target.sv
// bar_target_calc: next displayed height for one bar.
// Ports:
//   mag_i   - latched magnitude for the bar
//   seen_i  - bar received a beat in the current set
//   shift_i - right-shift scale applied to the magnitude
//   cur_i   - currently displayed height
//   next_o  - height to display after this commit (pure combinational)
// Rises instantly to the target; falls by at most DECAY_STEP per commit and
// never below the target.
module bar_target_calc
    import bar_frame_scheduler_pkg::*;
#(
    parameter logic [BAR_W-1:0] DECAY_STEP = 10'd8,
    parameter logic [BAR_W-1:0] MAX_H      = 10'd480
) (
    input  logic [MAG_W-1:0] mag_i,
    input  logic             seen_i,
    input  logic [3:0]       shift_i,
    input  logic [BAR_W-1:0] cur_i,
    output logic [BAR_W-1:0] next_o
);
    logic [MAG_W-1:0] shifted;
    logic [BAR_W-1:0] target;
    logic [BAR_W-1:0] decayed;

    // Clamp is evaluated on the full 16-bit value so large magnitudes cannot
    // alias into small heights through truncation.
    assign shifted = mag_i >> shift_i;
    assign target  = !seen_i                                ? '0    :
                     (shifted > {{(MAG_W-BAR_W){1'b0}}, MAX_H}) ? MAX_H :
                     shifted[BAR_W-1:0];

    assign decayed = (cur_i > DECAY_STEP) ? cur_i - DECAY_STEP : '0;

    always_comb begin
        next_o = target;
        if (target < cur_i && decayed > target)
            next_o = decayed;
    end
endmodule

// File: rtl/bar_frame_scheduler.sv
// bar_frame_scheduler: collects a set of FFT magnitude beats and commits them
// to the displayed bar heights only on a vertical-blanking rising edge, so a
// frame never shows a half-updated spectrum.
// Ports:
//   vgaclk, rst      - pixel clock, synchronous active-high reset
//   in_valid/in_ready, in_bin, in_mag, in_last - magnitude beat stream
//   shift            - magnitude scale applied at commit
//   vblank           - high during vertical blanking
//   bar_data         - displayed bar heights (registered)
//   frames_committed - committed sets, wraps
//   missed_frames    - vblank edges without a complete set, saturates
module bar_frame_scheduler
    import bar_frame_scheduler_pkg::*;
#(
    parameter logic [BAR_W-1:0] DECAY_STEP = 10'd8,
    parameter logic [BAR_W-1:0] MAX_H      = 10'd480
) (
    input  logic             vgaclk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_bin,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    input  logic [3:0]       shift,
    input  logic             vblank,
    output logic [BAR_W-1:0] bar_data [NUM_BARS-1:0],
    output logic [15:0]      frames_committed,
    output logic [7:0]       missed_frames
);
    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [MAG_W-1:0]        shadow_q [NUM_BARS-1:0];
    logic [NUM_BARS-1:0]     seen_q;
    logic [BAR_W-1:0]        bar_q    [NUM_BARS-1:0];
    logic [15:0]             frames_q;
    logic [7:0]              missed_q;
    logic                    vblank_d_q;
    logic                    vb_edge;
    logic [BAR_W-1:0]        bar_d;

    assign vb_edge = vblank && !vblank_d_q;

    // One calculator is time-shared across the four COMMIT cycles.
    bar_target_calc #(
        .DECAY_STEP (DECAY_STEP),
        .MAX_H      (MAX_H)
    ) u_calc (
        .mag_i   (shadow_q[idx_q]),
        .seen_i  (seen_q[idx_q]),
        .shift_i (shift),
        .cur_i   (bar_q[idx_q]),
        .next_o  (bar_d)
    );

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            idx_q      <= '0;
            seen_q     <= '0;
            frames_q   <= '0;
            missed_q   <= '0;
            // Preset high so vblank already asserted at reset release is not
            // mistaken for a fresh edge.
            vblank_d_q <= 1'b1;
            for (int i = 0; i < NUM_BARS; i++) begin
                shadow_q[i] <= '0;
                bar_q[i]    <= '0;
            end
        end else begin
            vblank_d_q <= vblank;
            case (state_q)
                ST_COLLECT: begin
                    // in_ready is high throughout COLLECT, so valid == accept.
                    if (in_valid) begin
                        shadow_q[in_bin] <= in_mag;
                        seen_q[in_bin]   <= 1'b1;
                        if (in_last)
                            state_q <= ST_PENDING;
                    end
                    // Partial set is kept; the display simply misses a frame.
                    if (vb_edge && missed_q != 8'hFF)
                        missed_q <= missed_q + 8'd1;
                end
                ST_PENDING: begin
                    if (vb_edge) begin
                        state_q <= ST_COMMIT;
                        idx_q   <= '0;
                    end
                end
                ST_COMMIT: begin
                    bar_q[idx_q] <= bar_d;
                    idx_q        <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        seen_q   <= '0;
                        frames_q <= frames_q + 16'd1;
                        state_q  <= ST_COLLECT;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign in_ready         = (state_q == ST_COLLECT);
    assign bar_data         = bar_q;
    assign frames_committed = frames_q;
    assign missed_frames    = missed_q;
endmodule

// File: doc/bar_frame_scheduler.md
BAR_FRAME_SCHEDULER -- requirements
Module: bar_frame_scheduler

Interface
REQ-001 SHALL: parameter DECAY_STEP, 10'd8, maximum per-frame fall of a displayed bar.
REQ-002 SHALL: parameter MAX_H, 10'd480, clamp ceiling for bar height (active lines).
REQ-003 SHALL: vgaclk  input  1  pixel clock; all state on rising edge.
REQ-004 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL: in_valid  input  1  magnitude beat valid.
REQ-006 SHALL: in_ready  output  1  scheduler accepts beat.
REQ-007 SHALL: in_bin  input  2  bar index 0..3 of beat.
REQ-008 SHALL: in_mag  input  16  unsigned FFT magnitude.
REQ-009 SHALL: in_last  input  1  final beat of one spectrum set.
REQ-010 SHALL: shift  input  4  right-shift scale applied to in_mag at commit.
REQ-011 SHALL: vblank  input  1  display done flag, high during vertical blanking.
REQ-012 SHALL: bar_data  output  4x10 (unpacked [3:0])  displayed bar heights.
REQ-013 SHALL: frames_committed  output  16  count of committed sets, wraps.
REQ-014 SHALL: missed_frames  output  8  vblank edges with no complete set, saturates at 255.

Function
REQ-015 SHALL: beat accepted only when in_valid && in_ready in same cycle.
REQ-016 SHALL: FSM states COLLECT, PENDING, COMMIT; COLLECT drives in_ready=1, others 0.
REQ-017 SHALL: in COLLECT, accepted beat writes shadow[in_bin]=in_mag and sets seen[in_bin]; duplicate bin in one set: last write wins.
REQ-018 SHALL: accepted beat with in_last=1 moves COLLECT->PENDING next cycle (set may contain 1..N beats).
REQ-019 SHALL: vblank rising edge = vblank && !vblank_d, vblank_d registered every cycle.
REQ-020 SHALL: PENDING holds until a vblank rising edge, then -> COMMIT next cycle; set never committed mid-frame.
REQ-021 SHALL: COMMIT lasts exactly 4 cycles, bar index i=0..3 in order; bar_data[i] updates at end of COMMIT cycle i.
REQ-022 SHALL: target_i = seen[i] ? min(shadow[i] >> shift, MAX_H) : 0, computed at 16 bits before truncation to 10.
REQ-023 SHALL: if target_i >= bar_data[i], bar_data[i] <= target_i (instant attack); else bar_data[i] <= max(bar_data[i]-DECAY_STEP, target_i), no underflow.
REQ-024 SHALL: after COMMIT cycle 3: seen cleared, frames_committed +1 (wrap 0xFFFF->0), state -> COLLECT.
REQ-025 SHALL: vblank rising edge while in COLLECT increments missed_frames (saturating); bar_data unchanged; partial set retained.
REQ-026 SHALL: vblank edges during COMMIT ignored (not counted).
REQ-027 SHALL: beats presented while in_ready=0 are not consumed; upstream holds them.

Reset
REQ-028 SHALL: on rst: state=COLLECT, bar_data all 0, shadow all 0, seen=0, frames_committed=0, missed_frames=0, vblank_d=1 (no spurious edge if vblank high out of reset).
REQ-029 SHALL: rst mid-PENDING or mid-COMMIT aborts set; no partial bar update after rst cycle.
REQ-030 SHALL: in_ready=1 the first cycle after rst deasserts.

Structure
REQ-031 SHALL: shared package holds state enum, NUM_BARS=4, BAR_W=10, MAG_W=16.
REQ-032 SHALL: one sub-module bar_target_calc (shift, clamp, attack/decay for one bar), used by COMMIT sequencer.
REQ-033 SHALL: bar_data output registered; no combinational path input->bar_data.

Verification
REQ-034 SHALL: beats (0,100),(1,200),(2,300),(3,400,last), shift=0, vblank edge -> bar_data={100,200,300,400} after 4 COMMIT cycles, frames_committed=1.
REQ-035 SHALL: bar_data[0]=400, next set bin0 mag=0 only -> bar_data[0]=392 per committed frame, reaching 0 after 50 commits; bins 1..3 same decay.
REQ-036 SHALL: in_mag=0xFFFF, shift=4 -> target 4095 clamped, bar_data=480.
REQ-037 SHALL: 3 vblank edges with no in_last -> missed_frames=3, bar_data unchanged, in_ready stays 1.
REQ-038 SHALL: set completes mid-frame, in_valid held high -> in_ready=0 until COMMIT ends, beat accepted first COLLECT cycle.
REQ-039 SHALL: rst asserted on COMMIT cycle 1 -> bar_data all 0 next cycle, state COLLECT, counters 0.
